snoop_responder: RTL and testbench

SNOOP_RESPONDER -- requirements
Module: snoop_responder

---
 rtl/LLC_defs.sv | 28 ++
 rtl/snoop_responder_pkg.sv | 47 ++++
 rtl/snoop_responder_if.sv | 18 +
 rtl/snoop_dir.sv | 58 +++++
 rtl/snoop_responder.sv | 166 ++++++++++++++++
 tb/tb_snoop_responder.sv | 320 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/LLC_defs.sv
// Shared LLC bus vocabulary: bus operations, snoop results and MESI states.
// Latency: n/a (types only).
// Backpressure: n/a.
package LLC_defs;

  typedef enum logic [2:0] {
    NOBUSOP    = 3'd0,
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } busOperation;

  typedef enum logic [1:0] {
    NOHIT    = 2'd0,
    HIT      = 2'd1,
    HITM     = 2'd2,
    NORESULT = 2'd3
  } snoopResults;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    E = 2'd2,
    M = 2'd3
  } mesiState;

endpackage

// File: rtl/snoop_responder_pkg.sv
// Snoop responder local types and the MESI response/transition rules.
// Latency: n/a (pure functions).
// Backpressure: n/a.
package snoop_responder_pkg;
  import LLC_defs::*;

  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 6;
  localparam int WB_CNT_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_WB      = 2'd3
  } snoop_state_t;

  // Only READ/RWIM can see our data; WRITE/INVALIDATE never get a hit back.
  function automatic snoopResults resp_for(busOperation op, logic hit, mesiState st);
    if (!hit || !(op == READ || op == RWIM)) return NOHIT;
    return (st == M) ? HITM : HIT;
  endfunction

  function automatic mesiState next_mesi(busOperation op, logic hit, mesiState st);
    mesiState nxt;
    nxt = st;
    if (hit) begin
      case (op)
        READ:       nxt = S;
        RWIM:       nxt = I;
        INVALIDATE: if (st == S) nxt = I;
        default:    nxt = st;
      endcase
    end
    return nxt;
  endfunction

  // Another agent writing or invalidating a line we hold exclusively is illegal.
  function automatic logic is_proto_err(busOperation op, logic hit, mesiState st);
    return hit && ((op == WRITE) || (op == INVALIDATE && (st == M || st == E)));
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// LLC bus request / snoop response bundle.
// Ports: bus_valid/bus_ready/bus_op/bus_addr request, snoop_valid/snoop_result response.
// master = LLC side, slave = snoop responder side.
interface snoop_responder_if;
  import LLC_defs::*;

  logic        bus_valid;
  logic        bus_ready;
  busOperation bus_op;
  logic [31:0] bus_addr;
  logic        snoop_valid;
  snoopResults snoop_result;

  modport master (output bus_valid, bus_op, bus_addr,
                  input  bus_ready, snoop_valid, snoop_result);
  modport slave  (input  bus_valid, bus_op, bus_addr,
                  output bus_ready, snoop_valid, snoop_result);
endinterface

// File: rtl/snoop_dir.sv
// Direct-mapped remote-cache directory: valid/tag/mesi per entry.
// Ports: one write port (wr_*), one combinational read port (rd_*); write lands at the clock edge.
// Latency: read is same-cycle; writes visible the cycle after wr_en. No backpressure.
module snoop_dir
  import LLC_defs::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_valid,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  mesiState            wr_mesi,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output mesiState            rd_mesi
);
  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_d  [ENTRIES];
  mesiState            mesi_q [ENTRIES];
  mesiState            mesi_d [ENTRIES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    mesi_d  = mesi_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
      tag_d[wr_idx]   = wr_tag;
      mesi_d[wr_idx]  = wr_mesi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < ENTRIES; k++) begin
        tag_q[k]  <= '0;
        mesi_q[k] <= I;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      mesi_q  <= mesi_d;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_mesi  = mesi_q[rd_idx];
endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: answers LLC bus ops against a directory of one remote cache.
// Ports: clk/rst_n, bus (request+response), hitm_wb_busy, proto_err, fill_* seeding, *_cnt counters.
// Latency: handshake at edge T -> snoop_valid sampled at T+2; HITM adds WB_CYCLES busy cycles.
// Backpressure: bus_ready/fill_ready high only when IDLE.
module snoop_responder
  import LLC_defs::*;
  import snoop_responder_pkg::*;
#(
  parameter int IDX_BITS  = 4,
  parameter int WB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  snoop_responder_if.slave    bus,
  output logic                hitm_wb_busy,
  output logic                proto_err,
  input  logic                fill_en,
  output logic                fill_ready,
  input  logic [31:0]         fill_addr,
  input  mesiState            fill_mesi,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         hitm_cnt,
  output logic [31:0]         nohit_cnt
);
  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS - IDX_BITS;

  snoop_state_t            state_q, state_d;
  busOperation             op_q, op_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic                    hit_q, hit_d;
  mesiState                lk_mesi_q, lk_mesi_d;
  logic [WB_CNT_BITS-1:0]  wb_cnt_q, wb_cnt_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             hitm_cnt_q, hitm_cnt_d;
  logic [31:0]             nohit_cnt_q, nohit_cnt_d;

  logic                    rd_valid;
  logic [TAG_BITS-1:0]     rd_tag;
  mesiState                rd_mesi;
  logic                    dir_wr_en, fill_wr, upd_wr;
  logic [IDX_BITS-1:0]     dir_wr_idx;
  logic [TAG_BITS-1:0]     dir_wr_tag;
  mesiState                dir_wr_mesi;

  logic                    idle, bus_hs, wb_last;
  snoopResults             resp;
  mesiState                upd_mesi;
  logic                    offset_unused;

  assign offset_unused = ^{bus.bus_addr[OFFSET_BITS-1:0], fill_addr[OFFSET_BITS-1:0]};

  assign idle     = (state_q == ST_IDLE);
  assign bus_hs   = idle && bus.bus_valid;
  assign wb_last  = (wb_cnt_q == WB_CNT_BITS'(WB_CYCLES - 1));
  assign resp     = resp_for(op_q, hit_q, lk_mesi_q);
  assign upd_mesi = next_mesi(op_q, hit_q, lk_mesi_q);

  // Fill and update never overlap: fill only in IDLE, update only in RESPOND/WB.
  assign fill_wr = idle && fill_en;
  assign upd_wr  = hit_q && (upd_mesi != lk_mesi_q) &&
                   (((state_q == ST_RESPOND) && (resp != HITM)) ||
                    ((state_q == ST_WB) && wb_last));
  assign dir_wr_en   = fill_wr || upd_wr;
  assign dir_wr_idx  = upd_wr ? idx_q : fill_addr[OFFSET_BITS +: IDX_BITS];
  assign dir_wr_tag  = upd_wr ? tag_q : fill_addr[ADDR_BITS-1 -: TAG_BITS];
  assign dir_wr_mesi = upd_wr ? upd_mesi : fill_mesi;

  snoop_dir #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) u_dir (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (dir_wr_en),
    .wr_idx   (dir_wr_idx),
    .wr_valid (dir_wr_mesi != I),
    .wr_tag   (dir_wr_tag),
    .wr_mesi  (dir_wr_mesi),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_mesi  (rd_mesi)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= NOBUSOP;
      idx_q       <= '0;
      tag_q       <= '0;
      hit_q       <= 1'b0;
      lk_mesi_q   <= I;
      wb_cnt_q    <= '0;
      hit_cnt_q   <= '0;
      hitm_cnt_q  <= '0;
      nohit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      hit_q       <= hit_d;
      lk_mesi_q   <= lk_mesi_d;
      wb_cnt_q    <= wb_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      hitm_cnt_q  <= hitm_cnt_d;
      nohit_cnt_q <= nohit_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus_hs && bus.bus_op != NOBUSOP) state_d = ST_LOOKUP;
      ST_LOOKUP:  state_d = ST_RESPOND;
      ST_RESPOND: state_d = (resp == HITM) ? ST_WB : ST_IDLE;
      ST_WB:      if (wb_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    op_d        = op_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    hit_d       = hit_q;
    lk_mesi_d   = lk_mesi_q;
    wb_cnt_d    = wb_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    hitm_cnt_d  = hitm_cnt_q;
    nohit_cnt_d = nohit_cnt_q;
    if (bus_hs && bus.bus_op != NOBUSOP) begin
      op_d  = bus.bus_op;
      idx_d = bus.bus_addr[OFFSET_BITS +: IDX_BITS];
      tag_d = bus.bus_addr[ADDR_BITS-1 -: TAG_BITS];
    end
    if (state_q == ST_LOOKUP) begin
      hit_d     = rd_valid && (rd_tag == tag_q) && (rd_mesi != I);
      lk_mesi_d = rd_mesi;
    end
    if (state_q == ST_RESPOND) begin
      wb_cnt_d = '0;
      case (resp)
        HIT:     hit_cnt_d   = sat_inc(hit_cnt_q);
        HITM:    hitm_cnt_d  = sat_inc(hitm_cnt_q);
        default: nohit_cnt_d = sat_inc(nohit_cnt_q);
      endcase
    end
    if (state_q == ST_WB) wb_cnt_d = wb_cnt_q + 1'b1;
  end

  // Outputs.
  always_comb begin
    bus.bus_ready    = idle;
    fill_ready       = idle;
    bus.snoop_valid  = (state_q == ST_RESPOND);
    bus.snoop_result = (state_q == ST_RESPOND) ? resp : NORESULT;
    proto_err        = (state_q == ST_RESPOND) && is_proto_err(op_q, hit_q, lk_mesi_q);
    hitm_wb_busy     = (state_q == ST_WB);
  end

  assign hit_cnt   = hit_cnt_q;
  assign hitm_cnt  = hitm_cnt_q;
  assign nohit_cnt = nohit_cnt_q;
endmodule

// File: tb/tb_snoop_responder.sv
// Bench for snoop_responder: directed scenarios plus random traffic against a
// slot-scheduled behavioural model of the directory and response timing.
module tb_snoop_responder;
  import LLC_defs::*;

  localparam int IDX_BITS  = 4;
  localparam int WB_CYCLES = 4;
  localparam int ENTRIES   = 16;
  localparam int TAG_BITS  = 22;
  localparam logic [31:0] A0 = 32'h10019d94;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if bus_if();
  logic        fill_en;
  logic [31:0] fill_addr;
  mesiState    fill_mesi;
  logic        hitm_wb_busy, proto_err, fill_ready;
  logic [31:0] hit_cnt, hitm_cnt, nohit_cnt;

  snoop_responder #(.IDX_BITS(IDX_BITS), .WB_CYCLES(WB_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .hitm_wb_busy (hitm_wb_busy),
    .proto_err    (proto_err),
    .fill_en      (fill_en),
    .fill_ready   (fill_ready),
    .fill_addr    (fill_addr),
    .fill_mesi    (fill_mesi),
    .hit_cnt      (hit_cnt),
    .hitm_cnt     (hitm_cnt),
    .nohit_cnt    (nohit_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // slot s = the interval after the s-th rising edge. A request accepted at edge c
  // answers in slot c+1; counters show it from slot c+2; HITM holds busy for
  // slots c+2..c+1+WB_CYCLES; the directory change lands at the edge that frees the bus.
  int          slot = 0;
  bit          model_on = 0;
  bit          m_valid [ENTRIES];
  logic [21:0] m_tag   [ENTRIES];
  mesiState    m_mesi  [ENTRIES];
  int          free_slot = 0;
  bit          pend_upd = 0;
  int          pend_idx;
  mesiState    pend_mesi;
  bit          exp_sv   [int];
  snoopResults exp_res  [int];
  bit          exp_perr [int];
  bit          exp_busy [int];
  int          cnt_slot [$];
  snoopResults cnt_kind [$];
  int          m_hit = 0, m_hitm = 0, m_nohit = 0;

  always @(posedge clk) begin : model
    int          ix;
    logic [21:0] tg;
    bit          hit;
    mesiState    cur, nxt;
    snoopResults r;
    bit          perr;
    busOperation op;
    slot++;
    if (!rst_n) begin
      model_on = 1;
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0; m_tag[k] = '0; m_mesi[k] = I;
      end
      pend_upd = 0;
      free_slot = slot;
      exp_sv.delete(); exp_res.delete(); exp_perr.delete(); exp_busy.delete();
      cnt_slot.delete(); cnt_kind.delete();
      m_hit = 0; m_hitm = 0; m_nohit = 0;
    end else if (model_on) begin
      if (pend_upd && slot == free_slot) begin
        m_mesi[pend_idx]  = pend_mesi;
        m_valid[pend_idx] = (pend_mesi != I);
        pend_upd = 0;
      end
      if (slot - 1 >= free_slot) begin
        if (fill_en) begin
          ix = int'(fill_addr[9:6]);
          m_valid[ix] = (fill_mesi != I);
          m_tag[ix]   = fill_addr[31:10];
          m_mesi[ix]  = fill_mesi;
        end
        op = bus_if.bus_op;
        if (bus_if.bus_valid && op != NOBUSOP) begin
          ix  = int'(bus_if.bus_addr[9:6]);
          tg  = bus_if.bus_addr[31:10];
          cur = m_mesi[ix];
          hit = m_valid[ix] && (m_tag[ix] == tg) && (cur != I);
          if (hit && (op == READ || op == RWIM)) r = (cur == M) ? HITM : HIT;
          else r = NOHIT;
          perr = hit && (op == WRITE || (op == INVALIDATE && (cur == M || cur == E)));
          nxt = cur;
          if (hit && op == READ) nxt = S;
          if (hit && op == RWIM) nxt = I;
          if (hit && op == INVALIDATE && cur == S) nxt = I;
          exp_sv[slot+1] = 1; exp_res[slot+1] = r; exp_perr[slot+1] = perr;
          cnt_slot.push_back(slot + 2); cnt_kind.push_back(r);
          if (r == HITM) begin
            for (int k = 0; k < WB_CYCLES; k++) exp_busy[slot+2+k] = 1;
            free_slot = slot + 2 + WB_CYCLES;
          end else begin
            free_slot = slot + 2;
          end
          if (nxt != cur) begin
            pend_upd = 1; pend_idx = ix; pend_mesi = nxt;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int s;
    if (model_on) begin
      s = slot;
      while (cnt_slot.size() > 0 && cnt_slot[0] <= s) begin
        case (cnt_kind[0])
          HIT:     m_hit++;
          HITM:    m_hitm++;
          default: m_nohit++;
        endcase
        void'(cnt_slot.pop_front());
        void'(cnt_kind.pop_front());
      end
      check("snoop_valid", 32'(bus_if.snoop_valid), 32'(exp_sv.exists(s)));
      check("snoop_result", 32'(bus_if.snoop_result), 32'(exp_res.exists(s) ? exp_res[s] : NORESULT));
      check("proto_err", 32'(proto_err), 32'(exp_perr.exists(s) ? exp_perr[s] : 1'b0));
      check("hitm_wb_busy", 32'(hitm_wb_busy), 32'(exp_busy.exists(s)));
      check("bus_ready", 32'(bus_if.bus_ready), 32'(s >= free_slot));
      check("fill_ready", 32'(fill_ready), 32'(s >= free_slot));
      check("hit_cnt", hit_cnt, 32'(m_hit));
      check("hitm_cnt", hitm_cnt, 32'(m_hitm));
      check("nohit_cnt", nohit_cnt, 32'(m_nohit));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus_if.bus_valid = 1'b0;
    bus_if.bus_op    = NOBUSOP;
    bus_if.bus_addr  = '0;
    fill_en          = 1'b0;
    fill_addr        = '0;
    fill_mesi        = I;
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake edge.
  task automatic send(input busOperation op, input logic [31:0] addr,
                      input bit with_fill, input mesiState fm, output int hs);
    int guard = 0;
    while (bus_if.bus_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) fail_note("ready_timeout");
    bus_if.bus_valid = 1'b1;
    bus_if.bus_op    = op;
    bus_if.bus_addr  = addr;
    fill_en          = with_fill;
    fill_addr        = addr;
    fill_mesi        = fm;
    @(negedge clk);
    hs = slot;
    idle_inputs();
  endtask

  task automatic fill(input logic [31:0] addr, input mesiState fm);
    int hs;
    send(NOBUSOP, addr, 1'b1, fm, hs);
  endtask

  // Literal timing check: nothing in the LOOKUP slot, the answer in the next.
  task automatic expect_resp(input string name, input snoopResults r, input bit perr);
    check({name, "_lookup_quiet"}, 32'(bus_if.snoop_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus_if.snoop_valid), 32'd1);
    check({name, "_result"}, 32'(bus_if.snoop_result), 32'(r));
    check({name, "_perr"}, 32'(proto_err), 32'(perr));
  endtask

  function automatic logic [31:0] mk_addr(input logic [21:0] t, input logic [3:0] ix,
                                          input logic [5:0] off);
    return {t, ix, off};
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int hs;
    int busy_n;
    logic [21:0] tags [2];
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", 32'(bus_if.snoop_result), 32'(NORESULT));
    check("reset_ready", 32'(bus_if.bus_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty directory: miss.
    send(READ, A0, 1'b0, I, hs);
    expect_resp("cold_read", NOHIT, 1'b0);
    @(negedge clk);
    check("cold_nohit_cnt", nohit_cnt, 32'd1);

    // M line read: HITM, writeback, then line is S.
    fill(A0, M);
    send(READ, A0, 1'b0, I, hs);
    expect_resp("m_read", HITM, 1'b0);
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hitm_wb_busy === 1'b1) begin
        busy_n++;
        check("wb_ready_low", 32'(bus_if.bus_ready), 32'd0);
      end
    end
    check("wb_busy_cycles", 32'(busy_n), 32'(WB_CYCLES));
    check("wb_hitm_cnt", hitm_cnt, 32'd1);
    send(READ, A0, 1'b0, I, hs);
    expect_resp("after_wb_read", HIT, 1'b0);

    // E line RWIM: HIT, then gone.
    fill(A0, E);
    send(RWIM, A0, 1'b0, I, hs);
    expect_resp("e_rwim", HIT, 1'b0);
    @(negedge clk);
    send(READ, A0, 1'b0, I, hs);
    expect_resp("post_rwim_read", NOHIT, 1'b0);

    // Invalidate of an M line is illegal and leaves it M.
    fill(A0, M);
    send(INVALIDATE, A0, 1'b0, I, hs);
    expect_resp("m_inval", NOHIT, 1'b1);
    @(negedge clk);
    send(READ, A0, 1'b0, I, hs);
    expect_resp("still_m_read", HITM, 1'b0);

    // Fill S with a READ in the same cycle: the lookup sees the fill.
    send(READ, A0, 1'b1, S, hs);
    expect_resp("same_cycle_fill", HIT, 1'b0);
    // NOBUSOP handshake produces nothing.
    send(NOBUSOP, A0, 1'b0, I, hs);
    for (int k = 0; k < 3; k++) begin
      check("nobusop_quiet", 32'(bus_if.snoop_valid), 32'd0);
      @(negedge clk);
    end

    // Reset during writeback.
    fill(A0, M);
    send(READ, A0, 1'b0, I, hs);
    expect_resp("pre_reset_read", HITM, 1'b0);
    @(negedge clk);
    check("in_wb", 32'(hitm_wb_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(hitm_wb_busy), 32'd0);
    check("rst_valid", 32'(bus_if.snoop_valid), 32'd0);
    check("rst_hitm_cnt", hitm_cnt, 32'd0);
    check("rst_ready", 32'(bus_if.bus_ready), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus_if.snoop_valid), 32'd0);
    end
    send(READ, A0, 1'b0, I, hs);
    expect_resp("post_rst_read", NOHIT, 1'b0);

    // Random traffic over a small address pool so lines collide and hit.
    tags[0] = A0[31:10];
    tags[1] = 22'h2a5c3;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      bus_if.bus_valid = ($urandom_range(0, 2) == 0);
      bus_if.bus_op    = busOperation'($urandom_range(0, 4));
      bus_if.bus_addr  = mk_addr(tags[$urandom_range(0, 1)], 4'($urandom_range(5, 8)),
                                 6'($urandom));
      fill_en   = ($urandom_range(0, 3) == 0);
      fill_addr = mk_addr(tags[$urandom_range(0, 1)], 4'($urandom_range(5, 8)), 6'($urandom));
      fill_mesi = mesiState'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
